// File: rtl/unidad_control_riesgos_pkg.sv
// Shared types and defaults for the hazard/sequencing controller.
// Holds the mult/div FSM state encoding and default latency and counter widths.
package unidad_control_riesgos_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  localparam int MD_LAT_DEF = 4;
  localparam int CNT_W_DEF  = 16;
  // Wide enough for the largest legal latency (15).
  localparam int MD_CNT_W   = 4;

endpackage

// File: rtl/unidad_control_riesgos_contador_saturado.sv
// Up-counter that sticks at its maximum value instead of wrapping.
// Synchronous active-high reset.
module contador_saturado #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (inc && (q != '1))
      q <= q + W'(1);
  end

endmodule

// File: rtl/unidad_control_riesgos.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stalls,
// branch flushes, mult/div sequencing with HI/LO interlock and perf counters.
module unidad_control_riesgos
  import unidad_control_riesgos_pkg::*;
#(
  parameter int REG_BITS = 5,
  parameter int MD_LAT   = MD_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                id_is_muldiv,
  input  logic                id_reads_hilo,
  input  logic                ex_mem_read,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                ex_branch_taken,
  output logic                pc_write,
  output logic                if_id_write,
  output logic                if_id_flush,
  output logic                id_ex_bubble,
  output logic                md_start,
  output logic                md_busy,
  output logic                hilo_we,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  md_state_t           state, state_next;
  logic [MD_CNT_W-1:0] cnt, cnt_next;
  logic                hilo_next;
  logic                load_use, id_needs_md, md_stall, stall;

  assign md_busy     = (state == BUSY);
  assign load_use    = ex_mem_read && (ex_rd != '0) &&
                       ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));
  assign id_needs_md = id_is_muldiv || id_reads_hilo;
  // Evaluated on the current state, so a waiting muldiv issues one cycle after BUSY ends.
  assign md_stall    = md_busy && id_needs_md;
  assign stall       = load_use || md_stall;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    hilo_next  = 1'b0;
    md_start   = 1'b0;
    case (state)
      IDLE: begin
        md_start = !reset && id_is_muldiv && !ex_branch_taken && !load_use;
        if (md_start) begin
          cnt_next   = MD_CNT_W'(MD_LAT - 1);
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_next = IDLE;
          hilo_next  = 1'b1;
        end else begin
          cnt_next = cnt - MD_CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hilo_we <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      hilo_we <= hilo_next;
    end
  end

  contador_saturado #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall && !ex_branch_taken),
    .q     (stall_cnt)
  );

  contador_saturado #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ex_branch_taken),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_unidad_control_riesgos.sv
// Randomized + directed bench for unidad_control_riesgos; a behavioural model
// predicts each cycle's outputs into a queue that a negedge monitor consumes.
module tb_unidad_control_riesgos;

  localparam int RB     = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  typedef struct {
    int pc_write, if_id_write, if_id_flush, id_ex_bubble;
    int md_start, md_busy, hilo_we, stall_cnt, flush_cnt;
    int cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [RB-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic          id_uses_rs = 0, id_uses_rt = 0, id_is_muldiv = 0, id_reads_hilo = 0;
  logic          ex_mem_read = 0, ex_branch_taken = 0;
  logic          pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic          md_start, md_busy, hilo_we;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  unidad_control_riesgos #(.REG_BITS(RB), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .md_start(md_start), .md_busy(md_busy),
    .hilo_we(hilo_we), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks = 0, errors = 0, cyc = 0;

  // Model state: busy cycles still to come, pending HI/LO strobe, counter values.
  int m_busy_left = 0, m_hilo = 0, m_stall = 0, m_flush = 0;

  task automatic chk(input string name, input int act, input int exp, input int c);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc_write",     int'(pc_write),     e.pc_write,     e.cyc);
      chk("if_id_write",  int'(if_id_write),  e.if_id_write,  e.cyc);
      chk("if_id_flush",  int'(if_id_flush),  e.if_id_flush,  e.cyc);
      chk("id_ex_bubble", int'(id_ex_bubble), e.id_ex_bubble, e.cyc);
      chk("md_start",     int'(md_start),     e.md_start,     e.cyc);
      chk("md_busy",      int'(md_busy),      e.md_busy,      e.cyc);
      chk("hilo_we",      int'(hilo_we),      e.hilo_we,      e.cyc);
      chk("stall_cnt",    int'(stall_cnt),    e.stall_cnt,    e.cyc);
      chk("flush_cnt",    int'(flush_cnt),    e.flush_cnt,    e.cyc);
    end
  end

  // One cycle: apply inputs, predict outputs, advance the model across the edge.
  task automatic step(input bit rst, input int rs, input int rt, input bit urs, input bit urt,
                      input bit md, input bit rh, input bit mr, input int rd, input bit br);
    exp_t e;
    bit lu, busy, stl, start;
    reset = rst; id_rs = RB'(rs); id_rt = RB'(rt); id_uses_rs = urs; id_uses_rt = urt;
    id_is_muldiv = md; id_reads_hilo = rh; ex_mem_read = mr; ex_rd = RB'(rd);
    ex_branch_taken = br;

    lu    = mr && rd != 0 && ((urs && rd == rs) || (urt && rd == rt));
    busy  = m_busy_left > 0;
    stl   = lu || (busy && (md || rh));
    start = !rst && !busy && md && !br && !lu;

    e.cyc = cyc; e.md_start = start; e.md_busy = busy; e.hilo_we = m_hilo;
    e.stall_cnt = m_stall; e.flush_cnt = m_flush;
    if (rst)      begin e.pc_write = 0; e.if_id_write = 0; e.if_id_flush = 1; e.id_ex_bubble = 1; end
    else if (br)  begin e.pc_write = 1; e.if_id_write = 1; e.if_id_flush = 1; e.id_ex_bubble = 1; end
    else if (stl) begin e.pc_write = 0; e.if_id_write = 0; e.if_id_flush = 0; e.id_ex_bubble = 1; end
    else          begin e.pc_write = 1; e.if_id_write = 1; e.if_id_flush = 0; e.id_ex_bubble = 0; end
    sb.push_back(e);

    if (rst) begin
      m_busy_left = 0; m_hilo = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_hilo = (m_busy_left == 1);
      if (m_busy_left > 0) m_busy_left--;
      else if (start)      m_busy_left = MD_LAT;
      if (stl && !br && m_stall < CMAX) m_stall++;
      if (br && m_flush < CMAX)         m_flush++;
    end

    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(posedge clk); #1;
    // Reset held, then release with idle inputs.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Load-use on rs, then the same with ex_rd = 0 (no hazard), then on rt.
    step(0, 5, 0, 1, 0, 0, 0, 1, 5, 0);
    idle(1);
    step(0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    step(0, 3, 7, 0, 1, 0, 0, 1, 7, 0);
    step(0, 7, 3, 0, 1, 0, 0, 1, 7, 0);
    idle(1);
    // Flush with a simultaneous load-use.
    step(0, 5, 0, 1, 0, 0, 0, 1, 5, 1);
    idle(1);
    // Muldiv, then mfhi held in ID through BUSY and release.
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(2);
    // Back-to-back muldivs: second waits in ID, issues after BUSY ends.
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(6);
    // Branch during BUSY does not cancel the operation.
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(5);
    // Reset in the second BUSY cycle aborts; no HI/LO strobe afterwards.
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(6);
    // Saturation of both counters.
    for (int i = 0; i < 20; i++) step(0, 9, 0, 1, 0, 0, 0, 1, 9, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    // Random traffic; small register range so matches are frequent.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(63) == 0),
           $urandom_range(3), $urandom_range(3), $urandom_range(1), $urandom_range(1),
           ($urandom_range(3) == 0), ($urandom_range(3) == 0), $urandom_range(1),
           $urandom_range(3), ($urandom_range(7) == 0));
    end
    idle(2);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidad_control_riesgos.md
Name: unidad_control_riesgos

Overview:
Pipeline hazard and sequencing controller for the 5-stage procesador_segmentado (IF/ID/EX/MEM/WB).
- Detects load-use hazards and stalls the front end.
- Flushes on taken branches.
- Sequences the multi-cycle mult/div unit, blocking dependent instructions in ID until HI/LO is written.
- Keeps saturating stall and flush performance counters.

Parameters:
- REG_BITS, 5: register-specifier width.
- MD_LAT, 4: mult/div busy cycles after issue; legal range 1..15.
- CNT_W, 16: performance-counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_rs  in  REG_BITS  rs field of the instruction in ID.
- id_rt  in  REG_BITS  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_is_muldiv  in  1  ID holds mult/multu/div/divu.
- id_reads_hilo  in  1  ID holds mfhi/mflo.
- ex_mem_read  in  1  EX holds a load.
- ex_rd  in  REG_BITS  destination register of the EX instruction.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID register clear.
- id_ex_bubble  out  1  insert NOP into ID/EX.
- md_start  out  1  one-cycle mult/div launch pulse.
- md_busy  out  1  mult/div unit occupied.
- hilo_we  out  1  one-cycle HI/LO write strobe.
- stall_cnt  out  CNT_W  stall cycles, saturating.
- flush_cnt  out  CNT_W  flush events, saturating.

Behaviour:
Reset:
- While reset=1 at a rising edge: state<=IDLE, cnt<=0, hilo_we<=0, stall_cnt<=0, flush_cnt<=0.
- Combinational outputs while reset=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, md_start=0.
- Reset mid-BUSY aborts the operation; hilo_we is not issued.

Hazard terms (combinational):
- load_use = ex_mem_read & (ex_rd!=0) & ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
- id_needs_md = id_is_muldiv | id_reads_hilo.
- md_stall = md_busy & id_needs_md.
- stall = load_use | md_stall.

Output priority: flush > stall > normal.
- Flush (ex_branch_taken=1): pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1, md_start=0. Flush overrides any simultaneous stall.
- Stall (no flush): pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1.
- Normal: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.

Mult/div FSM, states IDLE and BUSY:
- IDLE: md_start = id_is_muldiv & ~ex_branch_taken & ~load_use. On md_start: cnt<=MD_LAT-1, state<=BUSY.
- BUSY: md_busy=1 (md_busy=0 in IDLE). If cnt==0: state<=IDLE and hilo_we<=1 (registered, high exactly one cycle). Otherwise cnt<=cnt-1.
- Latency: md_start in cycle t; md_busy high in cycles t+1..t+MD_LAT; hilo_we high in cycle t+MD_LAT+1, the same cycle a stalled mfhi/mflo is released.
- A flush does not cancel an operation already in BUSY.
- A muldiv waiting in ID is not issued in the cycle BUSY ends. It issues on the next IDLE cycle, since md_stall is evaluated on the current state.

Counters:
- stall_cnt increments every cycle with stall=1 and ex_branch_taken=0.
- flush_cnt increments every cycle with ex_branch_taken=1.
- Both hold at 2^CNT_W-1 (saturate, no wrap).

Decomposition:
- Shared package: FSM state encoding (IDLE=1'b0, BUSY=1'b1) and default MD_LAT / CNT_W constants.
- One sub-module, contador_saturado (parameter W; ports clk, reset, inc, q), instantiated twice for the counters.
- Hazard logic and the FSM stay in the top module.

Test Plan:
1. Reset held for 2 cycles -> pc_write=0, if_id_flush=1, id_ex_bubble=1, stall_cnt=0; after release with idle inputs -> pc_write=1, if_id_write=1, id_ex_bubble=0.
2. Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
3. Flush and stall together: ex_branch_taken=1 with a load-use match -> if_id_flush=1, pc_write=1, id_ex_bubble=1; flush_cnt increments, stall_cnt unchanged.
4. Mult/div sequencing with MD_LAT=4: muldiv in ID at cycle 0 -> md_start=1 at cycle 0, md_busy=1 cycles 1-4. mfhi held in ID from cycle 1 -> stalled cycles 1-4. Cycle 5: hilo_we=1, no stall.
5. Back-to-back muldivs -> the second stalls through BUSY and issues with md_start=1 in cycle 5.
6. Reset asserted in cycle 2 of BUSY -> md_busy=0 next cycle; hilo_we never pulses. Saturation check with CNT_W=4: 20 stall cycles -> stall_cnt=15.
